red_accum: RTL and testbench

- Parametrised, multi-cycle successor to the byte-lane reduction adder.
- Sums every lane of operands A and B (lane i of A plus lane i of B, over all lanes) into one OUT_W result. Optionally adds the result to a held accumulator.
- Supports signed/unsigned lanes, saturating or wrapping arithmetic, and an overflow flag.
- Sits beside the ALU as a multi-cycle functional unit with valid/ready handshakes on input and output.

---
 rtl/red_accum.sv | 149 ++++++++++++++
 tb/tb_red_accum.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/red_accum.sv
// Lane-serial reduction adder: sums lane i of a and b over all lanes into an OUT_W result, optionally on top of a held accumulator.
// Accept edge to out_valid is LANES+1 cycles (IDLE, LANES x RUN); in_ready is low until the result is taken via out_ready.
module red_accum #(
    parameter int LANE_W = 8,
    parameter int LANES  = 2,
    parameter int OUT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LANE_W-1:0]   a,
    input  logic [LANES*LANE_W-1:0]   b,
    input  logic                      signed_en,
    input  logic                      sat_en,
    input  logic                      acc_en,
    input  logic                      acc_clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          result,
    output logic                      ovfl
);

    localparam int DATA_W = LANES * LANE_W;
    localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int EXT_W  = OUT_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic              sgn_r;
    logic              sat_r;
    logic [IDX_W-1:0]  idx;
    logic [OUT_W-1:0]  run_sum;
    logic              run_ovfl;
    logic [OUT_W-1:0]  acc;

    logic [LANE_W-1:0] lane_a;
    logic [LANE_W-1:0] lane_b;
    logic [EXT_W-1:0]  ext_a;
    logic [EXT_W-1:0]  ext_b;
    logic [EXT_W-1:0]  ext_sum;
    logic [EXT_W-1:0]  t;
    logic [2:0]        top_bits;
    logic              over;
    logic [OUT_W-1:0]  clamp;
    logic [OUT_W-1:0]  next_sum;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < LANES; i++) begin
            if (idx == IDX_W'(i)) begin
                lane_a = a_r[i*LANE_W +: LANE_W];
                lane_b = b_r[i*LANE_W +: LANE_W];
            end
        end
    end

    // Two guard bits cover one running sum plus two lanes in either signedness
    always_comb begin
        ext_a   = sgn_r ? {{(EXT_W-LANE_W){lane_a[LANE_W-1]}}, lane_a}
                        : {{(EXT_W-LANE_W){1'b0}}, lane_a};
        ext_b   = sgn_r ? {{(EXT_W-LANE_W){lane_b[LANE_W-1]}}, lane_b}
                        : {{(EXT_W-LANE_W){1'b0}}, lane_b};
        ext_sum = sgn_r ? {{2{run_sum[OUT_W-1]}}, run_sum}
                        : {2'b00, run_sum};
        t        = ext_sum + ext_a + ext_b;
        top_bits = t[EXT_W-1:OUT_W-1];
    end

    always_comb begin
        over  = 1'b0;
        clamp = '1;
        if (sgn_r) begin
            over  = (top_bits != 3'b000) && (top_bits != 3'b111);
            clamp = t[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            // Zero-extended operands can never go below zero, so only the top bound applies
            over  = (t[EXT_W-1:OUT_W] != 2'b00);
            clamp = '1;
        end
        next_sum = (over && sat_r) ? clamp : t[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            sgn_r    <= 1'b0;
            sat_r    <= 1'b0;
            idx      <= '0;
            run_sum  <= '0;
            run_ovfl <= 1'b0;
            acc      <= '0;
            result   <= '0;
            ovfl     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (acc_clr) begin
                        acc <= '0;
                    end
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        sgn_r    <= signed_en;
                        sat_r    <= sat_en;
                        // A clear arriving with the request wins over the old accumulator
                        run_sum  <= (acc_en && !acc_clr) ? acc : '0;
                        run_ovfl <= 1'b0;
                        idx      <= '0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    run_sum  <= next_sum;
                    run_ovfl <= run_ovfl | over;
                    if (idx == LAST_IDX) begin
                        result <= next_sum;
                        ovfl   <= run_ovfl | over;
                        acc    <= next_sum;
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_red_accum.sv
// Directed bench for red_accum: default-parameter unit with a result scoreboard, plus a LANE_W=4/LANES=8/OUT_W=12 instance.
module tb_red_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        signed_en;
    logic        sat_en;
    logic        acc_en;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        ovfl;

    logic        sw_in_valid;
    logic        sw_in_ready;
    logic [31:0] sw_a;
    logic [31:0] sw_b;
    logic        sw_signed_en;
    logic        sw_out_valid;
    logic [11:0] sw_result;
    logic        sw_ovfl;

    int checks   = 0;
    int failures = 0;
    logic [16:0] exp_q[$];

    red_accum u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .signed_en (signed_en),
        .sat_en    (sat_en),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovfl      (ovfl)
    );

    red_accum #(.LANE_W(4), .LANES(8), .OUT_W(12)) u_sweep (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (sw_in_valid),
        .in_ready  (sw_in_ready),
        .a         (sw_a),
        .b         (sw_b),
        .signed_en (sw_signed_en),
        .sat_en    (1'b0),
        .acc_en    (1'b0),
        .acc_clr   (1'b0),
        .out_valid (sw_out_valid),
        .out_ready (1'b1),
        .result    (sw_result),
        .ovfl      (sw_ovfl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a request, pushes its expected outcome, and returns just after the accept edge
    task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic s,
                        input logic sat, input logic acc, input logic [15:0] er, input logic eo);
        int n = 0;
        a         = ta;
        b         = tb_v;
        signed_en = s;
        sat_en    = sat;
        acc_en    = acc;
        in_valid  = 1'b1;
        exp_q.push_back({eo, er});
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("accept_wait", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        a         = 16'($urandom);
        b         = 16'($urandom);
        signed_en = ~s;
        sat_en    = ~sat;
        acc_en    = ~acc;
    endtask

    // Called right after the accept edge; the accept edge counts as cycle 1
    task automatic collect(input string tag, input int lat);
        int cyc = 1;
        logic [16:0] e;
        while (!out_valid && cyc < 60) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_result"}, result, {16'h0, e[15:0]});
            chk({tag, "_ovfl"}, ovfl, {31'h0, e[16]});
        end
    endtask

    task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic s, input logic sat, input logic acc,
                       input logic [15:0] er, input logic eo);
        send(ta, tb_v, s, sat, acc, er, eo);
        collect(tag, 3);
        tick();
        chk({tag, "_back_idle"}, in_ready, 1);
    endtask

    task automatic sweep(input string tag, input logic s, input logic [11:0] er);
        int cyc = 1;
        sw_a         = 32'hFFFF_FFFF;
        sw_b         = 32'hFFFF_FFFF;
        sw_signed_en = s;
        sw_in_valid  = 1'b1;
        chk({tag, "_ready"}, sw_in_ready, 1);
        tick();
        sw_in_valid = 1'b0;
        sw_a        = 32'h0;
        while (!sw_out_valid && cyc < 60) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 9);
        chk({tag, "_result"}, sw_result, {20'h0, er});
        chk({tag, "_ovfl"}, sw_ovfl, 0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        signed_en    = 1'b0;
        sat_en       = 1'b0;
        acc_en       = 1'b0;
        acc_clr      = 1'b0;
        out_ready    = 1'b1;
        sw_in_valid  = 1'b0;
        sw_a         = '0;
        sw_b         = '0;
        sw_signed_en = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_ovfl", ovfl, 0);
        rst_n = 1'b1;
        tick();

        run("basic",   16'h7F01, 16'h0102, 1'b1, 1'b0, 1'b0, 16'h0083, 1'b0);
        run("neg_s",   16'hFFFF, 16'h80FE, 1'b1, 1'b0, 1'b0, 16'hFF7C, 1'b0);
        run("neg_u",   16'hFFFF, 16'h80FE, 1'b0, 1'b0, 1'b0, 16'h037C, 1'b0);

        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        run("acc1", 16'h0101, 16'h0101, 1'b1, 1'b0, 1'b1, 16'd4, 1'b0);
        run("acc2", 16'h0101, 16'h0101, 1'b1, 1'b0, 1'b1, 16'd8, 1'b0);
        run("acc3", 16'h0101, 16'h0101, 1'b1, 1'b0, 1'b1, 16'd12, 1'b0);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        run("acc_after_clr", 16'h0101, 16'h0101, 1'b1, 1'b0, 1'b1, 16'd4, 1'b0);
        acc_clr = 1'b1;
        run("acc_clr_same_cycle", 16'h0101, 16'h0101, 1'b1, 1'b0, 1'b1, 16'd4, 1'b0);
        acc_clr = 1'b0;

        // Preload the accumulator to 0x7FF0: 32 x 1020 + 112
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            run("preload", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'(k * 1020), 1'b0);
        end
        run("preload_top", 16'h3838, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h7FF0, 1'b0);
        run("sat_on",      16'h7F7F, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b1);
        run("reload",      16'h00F1, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h7FF0, 1'b0);
        run("sat_off",     16'h7F7F, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h80EE, 1'b1);

        // Abort during lane 1; the aborted request never produces output
        send(16'h7F01, 16'h0102, 1'b1, 1'b0, 1'b0, 16'h0083, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrun_out_valid", out_valid, 0);
        chk("midrun_result", result, 0);
        chk("midrun_ovfl", ovfl, 0);
        chk("midrun_in_ready", in_ready, 1);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        tick();
        run("post_reset_acc", 16'h0101, 16'h0101, 1'b1, 1'b0, 1'b1, 16'd4, 1'b0);

        out_ready = 1'b0;
        send(16'h7F01, 16'h0102, 1'b1, 1'b0, 1'b0, 16'h0083, 1'b0);
        collect("bp_first", 3);
        a         = 16'h0101;
        b         = 16'h0101;
        signed_en = 1'b1;
        sat_en    = 1'b0;
        acc_en    = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, 16'h0083);
            chk("bp_in_ready", in_ready, 0);
        end
        exp_q.push_back({1'b0, 16'd4});
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        collect("bp_second", 3);
        tick();

        sweep("sweep_u", 1'b0, 12'd240);
        sweep("sweep_s", 1'b1, 12'hFF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
